// File: rtl/spi_regbank_pkg.sv
// Shared constants for the SPI register bank: fast-command codes, FSM states,
// fixed addresses and the reset defaults of the six config registers.
// Pure declarations; no ports, no latency, no backpressure.
package spi_regbank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SNAP  = 2'd2
   } state_t;

   localparam logic [5:0] FC_CLEAR   = 6'h01;
   localparam logic [5:0] FC_SNAP    = 6'h02;
   localparam logic [5:0] FC_LOCK    = 6'h03;
   localparam logic [5:0] FC_UNLOCK  = 6'h04;
   localparam logic [5:0] FC_ERR_CLR = 6'h05;

   localparam int NUM_CFG   = 6;
   localparam int ADDR_SNAP = 6;
   localparam int ADDR_ID   = 7;

   // Reset / CLEAR values for config registers 0..5 (index 0 first).
   localparam logic [7:0] CFG_DEFAULT [NUM_CFG] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h80};

   function automatic logic fc_defined(input logic [5:0] code);
      return (code >= FC_CLEAR) && (code <= FC_ERR_CLR);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a bus of independent, slowly changing bits.
// Latency: 2 clk. No backpressure. Ports: clk, rst (async high), d in, q out.
module bit_sync #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_regbank.sv
// Register bank behind an SPI slave: 6 RW config regs, SNAP reg, ID reg, fast commands.
// Latency: read data 1 clk after reg_addr; writes/strobes visible 1 clk after the strobe.
// No backpressure: writes arriving while locked/busy/with a fastcmd are dropped and flag err.
// Ports: clk, rst (async high); reg_addr/reg_data_o/reg_data_o_vld write side;
// reg_data_i read data; status {busy,lock,err,snap_vld,wr_cnt}; fastcmd/fastcmd_vld;
// hw_in async snapshot source; cfg_out regs 0..5 (reg0 LSBs); wr_strobe per-reg pulse; irq = err.
module spi_regbank
   import spi_regbank_pkg::*;
#(
   parameter int               ADDR_W = 3,
   parameter int               REG_W  = 8,
   parameter logic [REG_W-1:0] ID_VAL = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_W-1:0]    reg_addr,
   input  logic [REG_W-1:0]     reg_data_o,
   input  logic                 reg_data_o_vld,
   output logic [REG_W-1:0]     reg_data_i,
   output logic [7:0]           status,
   input  logic [5:0]           fastcmd,
   input  logic                 fastcmd_vld,
   input  logic [REG_W-1:0]     hw_in,
   output logic [6*REG_W-1:0]   cfg_out,
   output logic [5:0]           wr_strobe,
   output logic                 irq
);

   state_t           state;
   logic [2:0]       clr_idx;
   logic [REG_W-1:0] cfg [NUM_CFG];
   logic [REG_W-1:0] snap_reg;
   logic [REG_W-1:0] hw_sync;
   logic             lock;
   logic             err;
   logic             snap_vld;
   logic [3:0]       wr_cnt;

   logic             idle;
   logic             wr_accept;
   logic             err_set;
   logic             err_clr;
   logic [REG_W-1:0] rd_mux;

   bit_sync #(.W(REG_W)) u_hw_sync (
      .clk (clk),
      .rst (rst),
      .d   (hw_in),
      .q   (hw_sync)
   );

   always_comb begin
      idle      = (state == ST_IDLE);
      wr_accept = reg_data_o_vld && (reg_addr <= ADDR_W'(NUM_CFG - 1)) && !lock && idle && !fastcmd_vld;
      // Any fastcmd while busy, or an unknown code, is an error; so is any dropped write.
      err_set   = (reg_data_o_vld && !wr_accept) ||
                  (fastcmd_vld && (!idle || !fc_defined(fastcmd)));
      err_clr   = fastcmd_vld && idle && (fastcmd == FC_ERR_CLR);
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CFG; i++) begin
         if (reg_addr == ADDR_W'(i)) rd_mux = cfg[i];
      end
      if (reg_addr == ADDR_W'(ADDR_SNAP)) rd_mux = snap_reg;
      if (reg_addr == ADDR_W'(ADDR_ID))   rd_mux = ID_VAL;
   end

   always_comb begin
      cfg_out = '0;
      for (int i = 0; i < NUM_CFG; i++) cfg_out[i*REG_W +: REG_W] = cfg[i];
      status = {!idle, lock, err, snap_vld, wr_cnt};
      irq    = err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         clr_idx    <= '0;
         for (int i = 0; i < NUM_CFG; i++) cfg[i] <= REG_W'(CFG_DEFAULT[i]);
         snap_reg   <= '0;
         lock       <= 1'b0;
         err        <= 1'b0;
         snap_vld   <= 1'b0;
         wr_cnt     <= '0;
         wr_strobe  <= '0;
         reg_data_i <= '0;
      end else begin
         reg_data_i <= rd_mux;
         wr_strobe  <= '0;

         if (wr_accept) begin
            for (int i = 0; i < NUM_CFG; i++) begin
               if (reg_addr == ADDR_W'(i)) begin
                  cfg[i]       <= reg_data_o;
                  wr_strobe[i] <= 1'b1;
               end
            end
            wr_cnt <= wr_cnt + 4'd1;
         end

         // Set beats clear when both happen in the same cycle.
         if (err_set)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;

         // snap_vld is consumed by an idle-cycle read of the SNAP address.
         if (state == ST_SNAP)                               snap_vld <= 1'b1;
         else if (idle && reg_addr == ADDR_W'(ADDR_SNAP))    snap_vld <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (fastcmd_vld) begin
                  case (fastcmd)
                     FC_CLEAR: begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                     end
                     FC_SNAP:   state <= ST_SNAP;
                     FC_LOCK:   lock  <= 1'b1;
                     FC_UNLOCK: lock  <= 1'b0;
                     default: ;
                  endcase
               end
            end
            ST_CLEAR: begin
               // One register per cycle; lock is deliberately not consulted here.
               for (int i = 0; i < NUM_CFG; i++) begin
                  if (clr_idx == 3'(i)) cfg[i] <= REG_W'(CFG_DEFAULT[i]);
               end
               if (clr_idx == 3'(NUM_CFG - 1)) state <= ST_IDLE;
               else                            clr_idx <= clr_idx + 3'd1;
            end
            ST_SNAP: begin
               snap_reg <= hw_sync;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
